// File: rtl/mccoy_prog_ctrl_if.sv
// Loader-side program port for the McCoy sequencer: valid/ready word transfer.
interface mccoy_prog_ctrl_if;
   logic       load_valid;
   logic [5:0] load_data;
   logic       load_ready;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/mccoy_prog_ctrl.sv
// McCoy program sequencer: buffers a program, then drives core instr/reset/run.
// Optional build macro MCCOY_CYCLE_COUNT_EN enables the cycles_run counter.
module mccoy_prog_ctrl #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned RST_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   mccoy_prog_ctrl_if.slave   load,
   input  logic               clear,
   input  logic               start,
   input  logic               step_mode,
   input  logic               step,
   input  logic               abort,
   input  logic [7:0]         pc_in,
   output logic [5:0]         instr_out,
   output logic               core_reset,
   output logic               core_run,
   output logic               done,
   output logic               busy,
   output logic [ADDR_W:0]    count,
   output logic [15:0]        cycles_run
);

   typedef enum logic [2:0] {S_IDLE, S_CORE_RST, S_RUN, S_STEP, S_DONE} state_t;

   localparam logic [ADDR_W:0] FULL     = DEPTH[ADDR_W:0];
   localparam logic [3:0]      RST_LAST = 4'(RST_CYCLES - 1);

   state_t     state_q, state_d;
   logic [5:0] mem [DEPTH];
   logic [3:0] rst_cnt_q;
   logic       step_mode_q;
   logic       step_q, step_q2;
   logic       wr_en, clr;
   logic [7:0] count_ext;
   logic       halt;

   // PC is compared at full width so out-of-range values never alias into the buffer
   assign count_ext = 8'(count);
   assign halt      = (pc_in >= count_ext);
   assign instr_out = halt ? '0 : mem[pc_in[ADDR_W-1:0]];
   assign done      = (state_q == S_DONE);
   assign busy      = (state_q == S_CORE_RST) || (state_q == S_RUN) || (state_q == S_STEP);

   always_comb begin
      state_d         = state_q;
      core_reset      = 1'b0;
      core_run        = 1'b0;
      load.load_ready = 1'b0;
      wr_en           = 1'b0;
      clr             = 1'b0;
      case (state_q)
         S_IDLE: begin
            core_reset      = 1'b1;
            load.load_ready = (count < FULL);
            wr_en           = load.load_valid && (count < FULL) && !clear;
            clr             = clear;
            if (start && !clear && (count != '0))
               state_d = S_CORE_RST;
         end
         S_CORE_RST: begin
            core_reset = 1'b1;
            if (rst_cnt_q == RST_LAST)
               state_d = step_mode_q ? S_STEP : S_RUN;
         end
         S_RUN: begin
            if (halt) state_d = S_DONE;
            else      core_run = 1'b1;
         end
         S_STEP: begin
            if (halt) state_d = S_DONE;
            else      core_run = step_q && !step_q2;
         end
         S_DONE: begin
            if (clear) begin
               clr     = 1'b1;
               state_d = S_IDLE;
            end else if (start) begin
               state_d = S_CORE_RST;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d = S_IDLE;
         clr     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         count       <= '0;
         rst_cnt_q   <= '0;
         step_mode_q <= 1'b0;
         step_q      <= 1'b0;
         step_q2     <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step;
         step_q2   <= step_q;
         rst_cnt_q <= (state_q == S_CORE_RST) ? rst_cnt_q + 4'd1 : '0;
         if (state_d == S_CORE_RST && state_q != S_CORE_RST)
            step_mode_q <= step_mode;
         if (clr)        count <= '0;
         else if (wr_en) count <= count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[count[ADDR_W-1:0]] <= load.load_data;
   end

`ifdef MCCOY_CYCLE_COUNT_EN
   logic [15:0] cyc_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cyc_q <= '0;
      else if (state_d == S_CORE_RST && state_q != S_CORE_RST)
         cyc_q <= '0;
      else if (core_run && cyc_q != '1)
         cyc_q <= cyc_q + 16'd1;
   end

   assign cycles_run = cyc_q;
`else
   assign cycles_run = '0;
`endif

endmodule

// File: tb/tb_mccoy_prog_ctrl.sv
// Randomized self-checking bench for mccoy_prog_ctrl against a queue-based program model.
module tb_mccoy_prog_ctrl;
   localparam int unsigned DEPTH      = 16;
   localparam int unsigned RST_CYCLES = 2;

   logic       clk = 1'b0;
   logic       reset, clear, start, step_mode, step, abort;
   logic [7:0] pc_in;
   logic [5:0] instr_out;
   logic       core_reset, core_run, done, busy;
   logic [4:0] count;
   logic [15:0] cycles_run;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [5:0] prog_q[$];

   mccoy_prog_ctrl_if ld_if ();

   mccoy_prog_ctrl #(.DEPTH(DEPTH), .ADDR_W(4), .RST_CYCLES(RST_CYCLES)) dut (
      .clk(clk), .reset(reset), .load(ld_if), .clear(clear), .start(start),
      .step_mode(step_mode), .step(step), .abort(abort), .pc_in(pc_in),
      .instr_out(instr_out), .core_reset(core_reset), .core_run(core_run),
      .done(done), .busy(busy), .count(count), .cycles_run(cycles_run)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned exp_instr(input logic [7:0] pc);
      return (pc < prog_q.size()) ? int'(prog_q[pc]) : 0;
   endfunction

   function automatic int unsigned exp_cyc(input int unsigned n);
`ifdef MCCOY_CYCLE_COUNT_EN
      return (n > 65535) ? 65535 : n;
`else
      return 0;
`endif
   endfunction

   function automatic logic [7:0] prog_pc();
      return 8'($urandom_range(0, prog_q.size() - 1));
   endfunction

   task automatic load_word(input logic [5:0] d);
      bit room;
      room = (prog_q.size() < DEPTH);
      ld_if.load_valid = 1'b1;
      ld_if.load_data  = d;
      #1;
      chk("load_ready", ld_if.load_ready, room);
      if (room) prog_q.push_back(d);
      tick();
      ld_if.load_valid = 1'b0;
      chk("count_after_load", count, prog_q.size());
   endtask

   task automatic begin_run(input bit sm);
      start = 1'b1; step_mode = sm; pc_in = 8'd0;
      tick();
      start = 1'b0;
      for (int i = 0; i < RST_CYCLES; i++) begin
         #1;
         chk("rst_core_reset", core_reset, 1);
         chk("rst_core_run", core_run, 0);
         chk("rst_busy", busy, 1);
         if (i == 0) chk("rst_cycles_clr", cycles_run, 0);
         tick();
      end
   endtask

   task automatic finish_halt(input int unsigned n_exp);
      int unsigned sz;
      sz = prog_q.size();
      pc_in = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(sz, 255));
      step = 1'b0;
      #1;
      chk("halt_core_run", core_run, 0);
      chk("halt_instr", instr_out, exp_instr(pc_in));
      tick();
      chk("done", done, 1);
      chk("done_busy", busy, 0);
      chk("done_core_reset", core_reset, 0);
      chk("done_core_run", core_run, 0);
      chk("done_cycles_run", cycles_run, exp_cyc(n_exp));
   endtask

   task automatic run_free(input int unsigned n, input int abort_at);
      begin_run(1'b0);
      for (int i = 0; i < int'(n); i++) begin
         if (i == abort_at) begin
            pc_in = 8'd2; abort = 1'b1;
            tick();
            abort = 1'b0;
            #1;
            chk("abort_core_reset", core_reset, 1);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_count", count, prog_q.size());
            return;
         end
         pc_in = prog_pc();
         #1;
         chk("run_core_run", core_run, 1);
         chk("run_core_reset", core_reset, 0);
         chk("run_instr", instr_out, exp_instr(pc_in));
         tick();
      end
      finish_halt(n);
   endtask

   task automatic run_step(input int unsigned pulses, input bit force_long);
      bit seq[$];
      bit prev1, prev2;
      int unsigned got;
      begin_run(1'b1);
      for (int unsigned k = 0; k < pulses; k++) begin
         repeat ($urandom_range(1, 3)) seq.push_back(1'b0);
         repeat ((force_long && k == 1) ? 5 : $urandom_range(1, 3)) seq.push_back(1'b1);
      end
      seq.push_back(1'b0); seq.push_back(1'b0);
      prev1 = 1'b0; prev2 = 1'b0; got = 0;
      foreach (seq[i]) begin
         step  = seq[i];
         pc_in = prog_pc();
         #1;
         // the run pulse follows the cycle in which step was first seen high
         chk("step_core_run", core_run, prev1 & ~prev2);
         chk("step_instr", instr_out, exp_instr(pc_in));
         got += core_run;
         prev2 = prev1; prev1 = seq[i];
         tick();
      end
      step = 1'b0;
      chk("step_pulses", got, pulses);
      finish_halt(pulses);
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
      abort = 1'b0; pc_in = 8'd0;
      ld_if.load_valid = 1'b0; ld_if.load_data = 6'd0;
      #2;
      chk("reset_core_reset", core_reset, 1);
      chk("reset_core_run", core_run, 0);
      chk("reset_done", done, 0);
      chk("reset_busy", busy, 0);
      chk("reset_load_ready", ld_if.load_ready, 1);
      chk("reset_instr", instr_out, 0);
      chk("reset_cycles_run", cycles_run, 0);
      chk("reset_count", count, 0);
      tick();
      reset = 1'b0;
      tick();

      load_word(6'h05); load_word(6'h0A); load_word(6'h3F);
      pc_in = 8'd1; #1;
      chk("instr_pc1", instr_out, 6'h0A);
      tick();
      run_free(7, -1);
      run_step(4, 1'b1);

      start = 1'b1; clear = 1'b1;
      tick();
      start = 1'b0; clear = 1'b0;
      prog_q.delete();
      chk("done_clear_wins_busy", busy, 0);
      chk("done_clear_wins_count", count, 0);
      chk("done_clear_wins_reset", core_reset, 1);

      for (int i = 0; i < 17; i++) load_word(6'($urandom));
      chk("full_load_ready", ld_if.load_ready, 0);
      pc_in = 8'd255; #1; chk("instr_pc255", instr_out, 0);
      pc_in = 8'd15;  #1; chk("instr_pc15", instr_out, exp_instr(8'd15));
      tick();

      run_free($urandom_range(3, 12), 1);
      run_free(5, -1);

      clear = 1'b1;
      tick();
      clear = 1'b0;
      prog_q.delete();
      ld_if.load_valid = 1'b1; ld_if.load_data = 6'h2A; clear = 1'b1;
      tick();
      ld_if.load_valid = 1'b0; clear = 1'b0;
      chk("clear_beats_load_count", count, 0);
      chk("clear_beats_load_ready", ld_if.load_ready, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("empty_start_busy", busy, 0);
         chk("empty_start_core_reset", core_reset, 1);
         tick();
      end

      for (int it = 0; it < 6; it++) begin
         int unsigned n_words;
         n_words = $urandom_range(1, 16);
         for (int unsigned w = 0; w < n_words; w++) load_word(6'($urandom));
         if ($urandom_range(0, 1) == 0) run_free($urandom_range(1, 20), -1);
         else                           run_step($urandom_range(1, 5), 1'b0);
         clear = 1'b1;
         tick();
         clear = 1'b0;
         prog_q.delete();
         chk("loop_clear_count", count, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
